// File: rtl/dmem_ctrl_if.sv
// rtl/dmem_ctrl_if.sv - datapath <-> data memory controller request/response bundle
interface dmem_ctrl_if;
  logic        MemRead;
  logic        MemWrite;
  logic        ByteEn;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        Done;
  logic        Err;

  modport master (
    output MemRead, MemWrite, ByteEn, Addr, WriteData,
    input  ReadData, Stall, Done, Err
  );

  modport slave (
    input  MemRead, MemWrite, ByteEn, Addr, WriteData,
    output ReadData, Stall, Done, Err
  );
endinterface

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - multi-cycle data memory controller with byte stores (option: DMEM_RANGE_CHECK_EN)
module dmem_ctrl #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input logic       clk,
  input logic       reset,
  dmem_ctrl_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic          be_q, be_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [31:0]   mem_q [DEPTH];

  logic          req;
  logic          access;
  logic          oor;
  logic          mem_we;
  logic [IW-1:0] idx;
  logic [31:0]   old_word;
  logic [31:0]   new_word;

  assign req      = bus.MemRead | bus.MemWrite;
  assign idx      = addr_q[IW+1:2];
  assign old_word = mem_q[idx];
  assign access   = (state_q == S_WAIT) && (cnt_q == '0);
  assign mem_we   = access && wr_q && !oor;

`ifdef DMEM_RANGE_CHECK_EN
  // Anything at or beyond DEPTH*4 bytes is out of range.
  assign oor = (addr_q[31:IW+2] != '0);
`else
  // Upper address bits are ignored; the address wraps around the RAM.
  logic unused_addr_hi;
  assign oor            = 1'b0;
  assign unused_addr_hi = ^addr_q[31:IW+2];
`endif

  // Merge the store data into the current word (single lane for byte stores).
  always_comb begin
    new_word = wdata_q;
    if (be_q) begin
      new_word = old_word;
      new_word[8*addr_q[1:0] +: 8] = wdata_q[7:0];
    end
  end

  // Next-state, request capture and access result.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          wr_d    = bus.MemWrite;
          be_d    = bus.ByteEn;
          addr_d  = bus.Addr;
          wdata_d = bus.WriteData;
          cnt_d   = CW'(LATENCY - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = oor ? 32'h0 : old_word;
          err_d   = oor;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control/state registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      be_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM array, not reset; written only on the edge that completes a store.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= new_word;
  end

  assign bus.Stall    = reset && (((state_q == S_IDLE) && req) || (state_q == S_WAIT));
  assign bus.Done     = (state_q == S_DONE);
  assign bus.Err      = (state_q == S_DONE) && err_q;
  assign bus.ReadData = rdata_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - scoreboard bench for dmem_ctrl with a word-array reference model
module tb_dmem_ctrl;
  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  dmem_ctrl_if bus0();
  dmem_ctrl_if bus1();

  dmem_ctrl #(.DEPTH(64), .LATENCY(2)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  dmem_ctrl #(.DEPTH(64), .LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_load;
    bit          known;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] ref_mem [64];
  bit          ref_valid [64];
  int          stall_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: scores every completion pulse of the LATENCY=2 instance.
  always @(negedge clk) begin
    if (!reset) begin
      stall_run = 0;
    end else begin
      if (bus0.Stall) stall_run++;
      if (bus0.Done) begin
        chk("stall_len", stall_run, 3);
        chk("stall_in_done", {31'b0, bus0.Stall}, 0);
        stall_run = 0;
        chk("sb_nonempty", {31'b0, sbq.size() != 0}, 1);
        if (sbq.size() != 0) begin
          exp_t e;
          e = sbq.pop_front();
          if (e.is_load && e.known) chk("read_data", bus0.ReadData, e.rdata);
          chk("err", {31'b0, bus0.Err}, {31'b0, e.err});
        end
      end
    end
  end

  task automatic drive0(input logic rd, input logic wr, input logic be,
                        input logic [31:0] addr, input logic [31:0] wdata);
    bus0.MemRead = rd; bus0.MemWrite = wr; bus0.ByteEn = be;
    bus0.Addr = addr; bus0.WriteData = wdata;
  endtask

  // Reference model: RAM of 64 words, byte address divided by 4.
  task automatic do_access(input logic rd, input logic wr, input logic be,
                           input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    int   i;
    bit   oor;
    bit   seen;
    int   n;
`ifdef DMEM_RANGE_CHECK_EN
    oor = (addr >= 32'd256);
`else
    oor = 1'b0;
`endif
    i = (addr / 4) % 64;
    e.is_load = rd;
    e.err     = oor;
    e.known   = oor ? 1'b1 : ref_valid[i];
    e.rdata   = oor ? 32'h0 : ref_mem[i];
    sbq.push_back(e);
    if (wr && !oor) begin
      if (be) ref_mem[i][8*(addr % 4) +: 8] = wdata[7:0];
      else begin
        ref_mem[i]   = wdata;
        ref_valid[i] = 1'b1;
      end
    end
    @(posedge clk); #1;
    drive0(rd, wr, be, addr, wdata);
    seen = 0;
    n = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      if (bus0.Done) seen = 1;
      n++;
    end
    chk("done_seen", {31'b0, seen}, 1);
    @(posedge clk); #1;
    drive0(0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b0;
    drive0(0, 0, 0, 0, 0);
    bus1.MemRead = 0; bus1.MemWrite = 0; bus1.ByteEn = 0; bus1.Addr = 0; bus1.WriteData = 0;
    for (int k = 0; k < 64; k++) begin ref_mem[k] = 0; ref_valid[k] = 0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'b0, bus0.Stall}, 0);
    chk("rst_done", {31'b0, bus0.Done}, 0);
    chk("rst_err", {31'b0, bus0.Err}, 0);
    chk("rst_rdata", bus0.ReadData, 0);
    chk("rst1_done", {31'b0, bus1.Done}, 0);
    reset = 1'b1;

    // Directed: word store/load, byte lanes, read+write priority, high address.
    do_access(0, 1, 0, 32'h10, 32'hDEADBEEF);
    do_access(1, 0, 0, 32'h10, 32'h0);
    do_access(0, 1, 0, 32'h10, 32'h11223344);
    do_access(0, 1, 1, 32'h12, 32'h000000AB);
    do_access(1, 0, 0, 32'h10, 32'h0);
    do_access(1, 1, 0, 32'h10, 32'h55AA55AA);
    do_access(1, 0, 0, 32'h10, 32'h0);
    do_access(0, 1, 0, 32'h0, 32'h01020304);
    do_access(0, 1, 0, 32'h100, 32'hCAFEF00D);
    do_access(1, 0, 0, 32'h0, 32'h0);
    do_access(1, 0, 0, 32'h100, 32'h0);

    // Reset in the first WAIT cycle aborts the pending store.
    do_access(0, 1, 0, 32'h20, 32'hAAAA5555);
    @(posedge clk); #1;
    drive0(0, 1, 0, 32'h20, 32'h12345678);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("abort_stall", {31'b0, bus0.Stall}, 0);
    chk("abort_done", {31'b0, bus0.Done}, 0);
    chk("abort_err", {31'b0, bus0.Err}, 0);
    chk("abort_rdata", bus0.ReadData, 0);
    drive0(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    do_access(1, 0, 0, 32'h20, 32'h0);

    // Randomized mix, including addresses beyond the RAM.
    for (int t = 0; t < 60; t++) begin
      int          op;
      logic [31:0] a;
      op = $urandom_range(0, 3);
      a  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) a = a + 32'h100 * 32'($urandom_range(1, 3));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      case (op)
        0: do_access(1, 0, 0, a, 32'h0);
        1: do_access(0, 1, 0, a, $urandom);
        2: do_access(0, 1, 1, a, $urandom);
        default: do_access(1, 1, $urandom_range(0, 1) == 1, a, $urandom);
      endcase
    end

    // LATENCY=1 instance: two loads held back to back.
    @(posedge clk); #1;
    bus1.MemRead = 1; bus1.Addr = 32'h4;
    for (int c = 0; c < 6; c++) begin
      bit dexp;
      @(negedge clk);
      dexp = (c == 2) || (c == 5);
      chk($sformatf("l1_done_c%0d", c), {31'b0, bus1.Done}, {31'b0, dexp});
      chk($sformatf("l1_stall_c%0d", c), {31'b0, bus1.Stall}, {31'b0, !dexp});
      @(posedge clk); #1;
    end
    bus1.MemRead = 0;

    repeat (4) @(posedge clk);
    chk("sb_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
